demux8bit_1x4_buf: RTL and testbench
====================================

// Module: demux8bit_1x4_buf
// PURPOSE
//  Buffered 1-to-4 demultiplexer: the write-side counterpart of the 4x1 read-select muxes.
//  Takes one 8-bit data stream from the datapath (e.g. a store to a memory-mapped output port).
//  Steers each accepted byte by a 2-bit select into one of four per-channel FIFOs.
//  Each channel presents a valid/ready interface to its downstream consumer.
//  Sits between the core's write-back/store path and the peripheral output channels.
// PARAMETERS
//  WIDTH  8  data width per beat
//  DEPTH  2  entries per channel FIFO (power of 2, >=2)
//  AW     1  pointer width, = log2(DEPTH)
// PORTS
//  clk          in   1          single clock, all state updates on rising edge
//  reset        in   1          synchronous, active-high
//  in_valid     in   1          upstream beat present
//  in_sel       in   2          destination channel 0..3
//  in_data      in   WIDTH      upstream data
//  in_ready     out  1          selected channel can accept this cycle
//  out_valid    out  4          channel k has data (bit k)
//  out_data     out  4*WIDTH    channel k data = out_data[k*WIDTH +: WIDTH]
//  out_ready    in   4          consumer k accepts (bit k)
//  ch_count     out  4*(AW+1)   occupancy of channel k = ch_count[k*(AW+1) +: AW+1]
//  overflow     out  1          sticky: in_valid seen while in_ready low
// BEHAVIOUR
//  - Reset (clk edge with reset=1): all counts=0, rd/wr pointers=0, out_valid=0, overflow=0.
//    out_data is don't-care while its out_valid=0. A reset mid-transfer discards all buffered data.
//  - Push: in_valid & in_ready at an edge writes in_data to FIFO[in_sel]. Only that channel changes.
//  - in_ready = (count[in_sel] != DEPTH); depends on current state and in_sel only.
//    There is no ready pass-through: a full channel being popped in the same cycle still reports in_ready=0.
//  - Pop: out_valid[k] & out_ready[k] at an edge retires the head of channel k.
//    All four channels may pop in the same cycle, independently.
//  - out_valid[k] = (count[k] != 0); out_data[k] = head entry, driven from registers (no in->out bypass).
//  - Latency: a byte pushed at edge N is visible on out_valid/out_data at the earliest after edge N.
//    This holds even when the channel was empty: one cycle minimum, no combinational path.
//  - Same-channel push+pop in one cycle: count unchanged, both pointers advance. Legal at any count where in_ready=1.
//  - Pointers wrap modulo DEPTH; count saturates logically at DEPTH via in_ready gating, never exceeds it.
//  - Per-channel ordering is strict FIFO; there is no ordering between channels.
//  - out_ready[k] with out_valid[k]=0: ignored, no state change.
//  - in_valid & !in_ready: the beat is not taken and overflow sets at that edge (sticky until reset).
//    Upstream must hold in_valid/in_sel/in_data until accepted.
//  - in_sel is sampled only when in_valid=1; X on in_sel with in_valid=0 must not corrupt state.
//  - ch_count reflects the registered count (post-edge value).
// TESTING
//  1. Reset, then push 0xA5 to sel=2 -> next cycle out_valid=4'b0100, ch2 data=0xA5, ch_count2=1; others 0.
//  2. With out_ready=0, push 0x11,0x22 to ch1 -> in_ready=0 for sel=1, in_ready=1 for sel=0.
//     Third push 0x33 to ch1 -> not accepted, overflow=1.
//  3. ch1 full {0x11,0x22}: push 0x33 with out_ready[1]=1 -> pop only, in_ready stays 0.
//     Next cycle in_ready=1, head=0x22, count=1.
//  4. ch0 count=1 (0x40): push 0x41 and pop in the same cycle -> count stays 1, head=0x41.
//     Repeat 8x with 0x42..0x49 to exercise pointer wrap; order preserved.
//  5. Fill ch0..ch3 with 0x00,0x10,0x20,0x30, then out_ready=4'b1111 for one cycle.
//     -> all four pop together, out_valid=4'b0000 after.
//  6. Push to ch3, assert reset mid-stream with out_ready=0 -> after that edge out_valid=0,
//     all ch_count=0, overflow=0, in_ready=1.

Source files
------------

// File: rtl/demux8bit_1x4_buf.sv
// rtl/demux8bit_1x4_buf.sv - buffered 1-to-4 byte demultiplexer with per-channel FIFOs
module demux8bit_1x4_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [1:0]           in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic [3:0]           out_valid,
    output logic [4*WIDTH-1:0]   out_data,
    input  logic [3:0]           out_ready,
    output logic [4*(AW+1)-1:0]  ch_count,
    output logic                 overflow
);

    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_CNT = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR = (AW)'(1);

    logic [WIDTH-1:0] mem    [4][DEPTH];
    logic [AW-1:0]    wr_ptr [4];
    logic [AW-1:0]    rd_ptr [4];
    logic [AW:0]      count  [4];

    logic       push;
    logic [3:0] push_ch;
    logic [3:0] pop;

    // No ready pass-through: a full channel stays not-ready even while popping.
    assign in_ready = (count[in_sel] != FULL);
    assign push     = in_valid & in_ready;

    always_comb begin
        push_ch = '0;
        pop     = '0;
        if (push) begin
            push_ch = 4'b0001 << in_sel;
        end
        for (int k = 0; k < 4; k++) begin
            pop[k] = (count[k] != '0) & out_ready[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
        end else begin
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
            for (int k = 0; k < 4; k++) begin
                if (push_ch[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + ONE_PTR;
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + ONE_PTR;
                end
                case ({push_ch[k], pop[k]})
                    2'b10:   count[k] <= count[k] + ONE_CNT;
                    2'b01:   count[k] <= count[k] - ONE_CNT;
                    default: count[k] <= count[k];
                endcase
            end
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (push_ch[k]) begin
                mem[k][wr_ptr[k]] <= in_data;
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        ch_count  = '0;
        for (int k = 0; k < 4; k++) begin
            out_valid[k]                 = (count[k] != '0);
            out_data[k*WIDTH +: WIDTH]   = mem[k][rd_ptr[k]];
            ch_count[k*(AW+1) +: AW+1]   = count[k];
        end
    end

endmodule

// File: tb/tb_demux8bit_1x4_buf.sv
// tb/tb_demux8bit_1x4_buf.sv - queue-model bench for demux8bit_1x4_buf
module tb_demux8bit_1x4_buf;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  in_sel;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [3:0]  out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_ready;
    logic [7:0]  ch_count;
    logic        overflow;

    demux8bit_1x4_buf #(.WIDTH(8), .DEPTH(DEPTH), .AW(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .ch_count  (ch_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit model_on = 1'b0;

    logic [7:0] mq [4][$];
    bit         m_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [3:0] ev;
        logic [7:0] ec;
        ev = '0;
        ec = '0;
        for (int k = 0; k < 4; k++) begin
            ev[k] = (mq[k].size() != 0);
            ec[k*2 +: 2] = 2'(mq[k].size());
            if (ev[k]) begin
                chk($sformatf("data_ch%0d", k), 32'(out_data[k*8 +: 8]), 32'(mq[k][0]));
            end
        end
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("ch_count", 32'(ch_count), 32'(ec));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("in_ready", 32'(in_ready), 32'(mq[in_sel].size() != DEPTH));
    endtask

    task automatic update_model();
        bit acc;
        bit [3:0] pops;
        if (reset) begin
            for (int k = 0; k < 4; k++) mq[k].delete();
            m_ovf = 1'b0;
        end else begin
            acc = in_valid && (mq[in_sel].size() < DEPTH);
            if (in_valid && !acc) m_ovf = 1'b1;
            for (int k = 0; k < 4; k++) pops[k] = out_ready[k] && (mq[k].size() != 0);
            for (int k = 0; k < 4; k++) if (pops[k]) void'(mq[k].pop_front());
            if (acc) mq[in_sel].push_back(in_data);
        end
    endtask

    // Drive at the falling edge, check pre-edge state, then advance the model across the rising edge.
    task automatic step(input logic r, input logic v, input logic [1:0] s,
                        input logic [7:0] d, input logic [3:0] ordy);
        @(negedge clk);
        reset = r; in_valid = v; in_sel = s; in_data = d; out_ready = ordy;
        #1;
        if (model_on) compare_model();
        update_model();
        @(posedge clk);
        #2;
    endtask

    task automatic peek_ready(input logic [1:0] s, input logic exp, input string name);
        in_valid = 1'b0;
        in_sel   = s;
        #1;
        chk(name, 32'(in_ready), 32'(exp));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'h0;
        step(1, 0, 0, 8'h00, 4'h0);
        step(1, 0, 0, 8'h00, 4'h0);
        model_on = 1'b1;
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_count", 32'(ch_count), 32'h0);

        // single push to channel 2
        step(0, 1, 2, 8'hA5, 4'h0);
        chk("t1_valid", 32'(out_valid), 32'b0100);
        chk("t1_data", 32'(out_data[23:16]), 32'hA5);
        chk("t1_count", 32'(ch_count), 32'h10);
        step(0, 0, 0, 8'h00, 4'b0100);

        // fill channel 1 and overrun it
        step(0, 1, 1, 8'h11, 4'h0);
        step(0, 1, 1, 8'h22, 4'h0);
        peek_ready(1, 1'b0, "t2_ready_full");
        peek_ready(0, 1'b1, "t2_ready_other");
        step(0, 1, 1, 8'h33, 4'h0);
        chk("t2_overflow", 32'(overflow), 32'h1);
        chk("t2_count1", 32'(ch_count[3:2]), 32'h2);

        // full channel popped while offered a push: pop only
        step(0, 1, 1, 8'h33, 4'b0010);
        chk("t3_ready", 32'(in_ready), 32'h1);
        chk("t3_head", 32'(out_data[15:8]), 32'h22);
        chk("t3_count", 32'(ch_count[3:2]), 32'h1);
        step(0, 0, 1, 8'h00, 4'b0010);

        // simultaneous push and pop across pointer wrap
        step(0, 1, 0, 8'h40, 4'h0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 8'(8'h41 + i), 4'b0001);
            chk("t4_count", 32'(ch_count[1:0]), 32'h1);
            chk("t4_head", 32'(out_data[7:0]), 32'(8'h41 + i));
        end
        step(0, 0, 0, 8'h00, 4'b0001);

        // all four channels pop together
        for (int k = 0; k < 4; k++) step(0, 1, 2'(k), 8'(k * 16), 4'h0);
        chk("t5_valid", 32'(out_valid), 32'hF);
        chk("t5_data", out_data, 32'h30201000);
        step(0, 0, 0, 8'h00, 4'hF);
        chk("t5_empty", 32'(out_valid), 32'h0);

        // reset mid-stream discards buffered data and clears overflow
        step(0, 1, 3, 8'h77, 4'h0);
        step(1, 1, 3, 8'h88, 4'h0);
        chk("t6_valid", 32'(out_valid), 32'h0);
        chk("t6_count", 32'(ch_count), 32'h0);
        chk("t6_overflow", 32'(overflow), 32'h0);
        chk("t6_ready", 32'(in_ready), 32'h1);

        for (int i = 0; i < 3000; i++) begin
            step(logic'($urandom_range(0, 199) == 0),
                 logic'($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)),
                 8'($urandom),
                 4'($urandom) & 4'($urandom));
        end
        step(0, 0, 0, 8'h00, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
